// File: rtl/mem_access_ctrl.sv
// Switch-driven memory access controller: debounced write/read buttons start a
// write-with-readback-verify or a plain read, with an ack timeout on every access.
module mem_access_ctrl #(
    parameter int DB_CYCLES      = 500000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_addr,
    input  logic [3:0] sw_data,
    input  logic       btn_wr,
    input  logic       btn_rd,
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    input  logic       mem_ack,
    output logic [3:0] direccion,
    output logic [3:0] datos,
    output logic       write_enable,
    output logic [1:0] resultado
);

    // state | meaning
    // IDLE  | waiting for a press event; display outputs hold last operation
    // WR    | write request outstanding
    // GAP   | one idle cycle between the write ack and the readback request
    // RB    | readback request outstanding, result from data compare
    // RD    | plain read request outstanding
    typedef enum logic [2:0] {IDLE, WR, GAP, RB, RD} state_t;

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_OK   = 2'b01;
    localparam logic [1:0] RES_FAIL = 2'b10;

    // bit 0 = write button, bit 1 = read button
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [1:0]      db_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]      direccion_q, direccion_d;
    logic [3:0]      datos_q, datos_d;
    logic            write_enable_q, write_enable_d;
    logic [1:0]      resultado_q, resultado_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_expired;

    always_comb begin
        db_lvl_d = db_lvl_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press      = db_lvl_q & ~db_prev_q;
    assign to_expired = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        direccion_d    = direccion_q;
        datos_d        = datos_q;
        write_enable_d = write_enable_q;
        resultado_d    = resultado_q;
        to_cnt_d       = to_cnt_q;

        case (state_q)
            IDLE: begin
                // write wins when both presses land in the same cycle
                if (press[0] || press[1]) begin
                    state_d        = press[0] ? WR : RD;
                    mem_req_d      = 1'b1;
                    mem_we_d       = press[0];
                    mem_addr_d     = sw_addr;
                    mem_wdata_d    = sw_data;
                    direccion_d    = sw_addr;
                    write_enable_d = press[0];
                    resultado_d    = RES_NONE;
                    to_cnt_d       = '0;
                    if (press[0]) begin
                        datos_d = sw_data;
                    end
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d   = GAP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (to_expired) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    resultado_d = RES_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            GAP: begin
                state_d   = RB;
                mem_req_d = 1'b1;
                mem_we_d  = 1'b0;
                to_cnt_d  = '0;
            end
            RB: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    resultado_d = (mem_rdata == mem_wdata_q) ? RES_OK : RES_FAIL;
                end else if (to_expired) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    resultado_d = RES_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    datos_d     = mem_rdata;
                    resultado_d = RES_OK;
                end else if (to_expired) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    resultado_d = RES_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            db_lvl_q       <= '0;
            db_prev_q      <= '0;
            db_cnt_q[0]    <= '0;
            db_cnt_q[1]    <= '0;
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            direccion_q    <= '0;
            datos_q        <= '0;
            write_enable_q <= 1'b0;
            resultado_q    <= RES_NONE;
            to_cnt_q       <= '0;
        end else begin
            sync1_q        <= {btn_rd, btn_wr};
            sync2_q        <= sync1_q;
            db_lvl_q       <= db_lvl_d;
            db_prev_q      <= db_lvl_q;
            db_cnt_q[0]    <= db_cnt_d[0];
            db_cnt_q[1]    <= db_cnt_d[1];
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            direccion_q    <= direccion_d;
            datos_q        <= datos_d;
            write_enable_q <= write_enable_d;
            resultado_q    <= resultado_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign direccion    = direccion_q;
    assign datos        = datos_q;
    assign write_enable = write_enable_q;
    assign resultado    = resultado_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a small memory responder plus a queue of
// expected operation outcomes checked when each access sequence finishes.
module tb_mem_access_ctrl;

    localparam int DB = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_addr, sw_data;
    logic       btn_wr, btn_rd;
    logic       mem_req, mem_we;
    logic [3:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack;
    logic [3:0] direccion, datos;
    logic       write_enable;
    logic [1:0] resultado;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sw_addr(sw_addr), .sw_data(sw_data),
        .btn_wr(btn_wr), .btn_rd(btn_rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .direccion(direccion), .datos(datos),
        .write_enable(write_enable), .resultado(resultado)
    );

    typedef struct {
        logic [1:0] res;
        logic [3:0] dir;
        logic [3:0] dat;
        logic       we;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;

    logic [3:0] mem_model [16];
    int         ack_delay = 2;
    bit         ack_en = 1'b1;
    bit         ovr_en = 1'b0;
    logic [3:0] ovr_val = 4'h0;

    // memory responder: acks after ack_delay extra cycles of mem_req
    initial begin
        int req_cnt;
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 4'h0;
        for (int i = 0; i < 16; i++) mem_model[i] = 4'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && ack_en) begin
                if (req_cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = ovr_en ? ovr_val : mem_model[mem_addr];
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_req(input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_req !== lvl && n < budget);
        chk("wait_mem_req", 8'(mem_req), 8'(lvl));
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_sb_avail"}, 8'(sb.size() > 0), 8'd1);
        e = sb.pop_front();
        chk({tag, "_resultado"}, 8'(resultado), 8'(e.res));
        chk({tag, "_direccion"}, 8'(direccion), 8'(e.dir));
        chk({tag, "_datos"}, 8'(datos), 8'(e.dat));
        chk({tag, "_write_enable"}, 8'(write_enable), 8'(e.we));
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (mem_req !== 1'b0) seen = 1'b1;
        end
        chk(tag, 8'(seen), 8'd0);
    endtask

    task automatic run_write(input logic [3:0] a, input logic [3:0] d, input bit bounce,
                             input bit ovr, input logic [3:0] ov);
        int   n;
        exp_t e;
        sw_addr = a; sw_data = d;
        ack_en = 1'b1; ack_delay = 2; ovr_en = ovr; ovr_val = ov;
        e.res = (ovr && ov != d) ? 2'b10 : 2'b01;
        e.dir = a; e.dat = d; e.we = 1'b1;
        sb.push_back(e);
        if (bounce) begin
            for (int i = 0; i < 3; i++) begin
                btn_wr = 1'b1; @(negedge clk);
                btn_wr = 1'b0; @(negedge clk);
                chk("bounce_no_req", 8'(mem_req), 8'd0);
            end
        end
        btn_wr = 1'b1;
        wait_req(1'b1, 20, n);
        chk("wr_press_latency", 8'(n), 8'd7);
        sw_addr = ~a; sw_data = ~d;
        chk("wr_mem_we", 8'(mem_we), 8'd1);
        chk("wr_mem_addr", 8'(mem_addr), 8'(a));
        chk("wr_mem_wdata", 8'(mem_wdata), 8'(d));
        chk("wr_resultado_busy", 8'(resultado), 8'd0);
        chk("wr_write_enable", 8'(write_enable), 8'd1);
        chk("wr_datos", 8'(datos), 8'(d));
        wait_req(1'b0, 20, n);
        chk("wr_req_cycles", 8'(n), 8'd3);
        @(negedge clk);
        chk("gap_one_cycle", 8'(mem_req), 8'd1);
        chk("rb_mem_we", 8'(mem_we), 8'd0);
        chk("rb_mem_addr", 8'(mem_addr), 8'(a));
        wait_req(1'b0, 20, n);
        chk("rb_req_cycles", 8'(n), 8'd3);
        check_done("wr");
        quiet("wr_single_event", 8);
        chk("wr_result_hold", 8'(resultado), 8'(e.res));
        btn_wr = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int   n;
        exp_t e;
        rst_n = 1'b0; btn_wr = 1'b0; btn_rd = 1'b0;
        sw_addr = 4'h0; sw_data = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 8'(mem_req), 8'd0);
        chk("rst_resultado", 8'(resultado), 8'd0);
        chk("rst_direccion", 8'(direccion), 8'd0);
        chk("rst_datos", 8'(datos), 8'd0);
        chk("rst_write_enable", 8'(write_enable), 8'd0);
        chk("rst_mem_addr", 8'(mem_addr), 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // bouncing press, verify ok; then readback mismatch
        run_write(4'h3, 4'hA, 1'b1, 1'b0, 4'h0);
        run_write(4'h3, 4'hA, 1'b0, 1'b1, 4'h5);

        // plain read
        ack_en = 1'b1; ack_delay = 1; ovr_en = 1'b1; ovr_val = 4'hC;
        sw_addr = 4'h7; sw_data = 4'h1;
        e.res = 2'b01; e.dir = 4'h7; e.dat = 4'hC; e.we = 1'b0;
        sb.push_back(e);
        btn_rd = 1'b1;
        wait_req(1'b1, 20, n);
        chk("rd_press_latency", 8'(n), 8'd7);
        chk("rd_mem_we", 8'(mem_we), 8'd0);
        chk("rd_mem_addr", 8'(mem_addr), 8'h7);
        chk("rd_write_enable", 8'(write_enable), 8'd0);
        chk("rd_resultado_busy", 8'(resultado), 8'd0);
        wait_req(1'b0, 20, n);
        chk("rd_req_cycles", 8'(n), 8'd2);
        check_done("rd");
        btn_rd = 1'b0;
        repeat (8) @(negedge clk);

        // read timeout with a write press landing during the wait
        ack_en = 1'b0; ovr_en = 1'b0;
        sw_addr = 4'h9; sw_data = 4'h2;
        btn_rd = 1'b1;
        wait_req(1'b1, 20, n);
        chk("to_press_latency", 8'(n), 8'd7);
        btn_rd = 1'b0; btn_wr = 1'b1;
        wait_req(1'b0, 20, n);
        chk("to_req_cycles", 8'(n), 8'd8);
        chk("to_resultado", 8'(resultado), 8'h2);
        chk("to_direccion", 8'(direccion), 8'h9);
        chk("to_datos_unchanged", 8'(datos), 8'hC);
        chk("to_write_enable", 8'(write_enable), 8'd0);
        quiet("to_press_discarded", 10);
        btn_wr = 1'b0;
        repeat (8) @(negedge clk);

        // simultaneous presses, reset during WR, held button after reset
        sw_addr = 4'h5; sw_data = 4'h6;
        btn_wr = 1'b1; btn_rd = 1'b1;
        wait_req(1'b1, 20, n);
        chk("both_press_latency", 8'(n), 8'd7);
        chk("both_is_write", 8'(mem_we), 8'd1);
        chk("both_write_enable", 8'(write_enable), 8'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 8'(mem_req), 8'd0);
        chk("arst_resultado", 8'(resultado), 8'd0);
        chk("arst_direccion", 8'(direccion), 8'd0);
        chk("arst_datos", 8'(datos), 8'd0);
        chk("arst_write_enable", 8'(write_enable), 8'd0);
        btn_rd = 1'b0;
        ack_en = 1'b1; ack_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        e.res = 2'b01; e.dir = 4'h5; e.dat = 4'h6; e.we = 1'b1;
        sb.push_back(e);
        wait_req(1'b1, 20, n);
        chk("post_rst_latency", 8'(n), 8'd7);
        wait_req(1'b0, 20, n);
        chk("post_rst_wr_cycles", 8'(n), 8'd1);
        @(negedge clk);
        chk("post_rst_gap", 8'(mem_req), 8'd1);
        wait_req(1'b0, 20, n);
        chk("post_rst_rb_cycles", 8'(n), 8'd1);
        check_done("post_rst");
        btn_wr = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
